// File: rtl/arashi_pkg.sv
// Shared constants and helpers for the arashi thread-cache arbiter.
// Holds the default sizes and the thread-index width function.
package arashi_pkg;

  localparam int unsigned DefNumThreads = 4;
  localparam int unsigned DefOutDepth   = 4;

  // A single thread still needs a 1-bit index so port widths stay legal.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arashi_thread_arbiter_if.sv
// Handshake bundle between the thread caches, the arbiter and the output consumer.
// The slave side is the arbiter; the master side drives caches and the consumer.
interface arashi_thread_arbiter_if
  import arashi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = DefNumThreads
) ();

  localparam int unsigned TidW = tid_width(NUM_THREADS);

  logic [NUM_THREADS-1:0]                 avail;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] cache_data;
  logic [NUM_THREADS-1:0]                 r_ena;
  logic                                   out_valid;
  logic [DATA_WIDTH-1:0]                  out_data;
  logic [TidW-1:0]                        out_tid;
  logic                                   out_ready;

  modport slave (
    input  avail,
    input  cache_data,
    input  out_ready,
    output r_ena,
    output out_valid,
    output out_data,
    output out_tid
  );

  modport master (
    output avail,
    output cache_data,
    output out_ready,
    input  r_ena,
    input  out_valid,
    input  out_data,
    input  out_tid
  );

endinterface

// File: rtl/arashi_rr_picker.sv
// Round-robin picker: first requester after the last granted index, wrapping.
// Purely combinational; the caller registers the result.
module arashi_rr_picker
  import arashi_pkg::*;
#(
  parameter int unsigned NumReq = DefNumThreads,
  parameter int unsigned IdxW   = tid_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;

  // NumReq is a power of two, so index arithmetic wraps by truncation;
  // the final iteration revisits last_i itself, allowing back-to-back grants.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = last_i + IdxW'(i);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/arashi_thread_arbiter.sv
// Arbitrates reads from several thread caches into one in-order output buffer.
// Grant -> r_ena (1 cycle) -> capture (1 cycle) -> buffer head, credit-limited.
module arashi_thread_arbiter
  import arashi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = DefNumThreads,
  parameter int unsigned OUT_DEPTH   = DefOutDepth
) (
  input  logic                          clk,
  input  logic                          rstn,
  arashi_thread_arbiter_if.slave        bus_io
);

  localparam int unsigned TidW = tid_width(NUM_THREADS);
  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Grant stage
  logic [NUM_THREADS-1:0] gnt;
  logic [TidW-1:0]        gnt_idx;
  logic                   gnt_any;
  logic                   issue;
  logic [NUM_THREADS-1:0] r_ena_q, r_ena_d;
  logic [TidW-1:0]        issue_tid_q;
  logic [TidW-1:0]        last_q, last_d;

  // Capture stage
  logic                   cap_vld_q;
  logic [TidW-1:0]        cap_tid_q;

  // Output buffer
  logic [DATA_WIDTH-1:0]  data_mem_q [OUT_DEPTH];
  logic [TidW-1:0]        tid_mem_q  [OUT_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic [1:0]             pending;
  logic [CntW:0]          occupancy;
  logic                   space;
  logic                   push, pop;
  logic                   out_valid;

  arashi_rr_picker #(
    .NumReq (NUM_THREADS),
    .IdxW   (TidW)
  ) u_picker (
    .req_i  (bus_io.avail),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  // Reads in flight reserve a slot; a same-cycle pop earns no credit.
  always_comb begin
    pending   = 2'(|r_ena_q) + 2'(cap_vld_q);
    occupancy = {1'b0, count_q} + (CntW + 1)'(pending);
    space     = occupancy < (CntW + 1)'(OUT_DEPTH);
    issue     = gnt_any && space;
    r_ena_d   = issue ? gnt : '0;
    last_d    = issue ? gnt_idx : last_q;
  end

  assign out_valid = (count_q != '0);
  assign push      = cap_vld_q;
  assign pop       = out_valid && bus_io.out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ena_q     <= '0;
      issue_tid_q <= '0;
      last_q      <= TidW'(NUM_THREADS - 1);
      cap_vld_q   <= 1'b0;
      cap_tid_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      r_ena_q     <= r_ena_d;
      issue_tid_q <= gnt_idx;
      last_q      <= last_d;
      cap_vld_q   <= |r_ena_q;
      cap_tid_q   <= issue_tid_q;
      count_q     <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus_io.cache_data[cap_tid_q];
      tid_mem_q[wr_ptr_q]  <= cap_tid_q;
    end
  end

  assign bus_io.r_ena     = r_ena_q;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus_io.out_tid   = out_valid ? tid_mem_q[rd_ptr_q] : '0;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && count_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && count_q == CntW'(OUT_DEPTH)));
  a_rena_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(r_ena_q));

endmodule

// File: doc/arashi_thread_arbiter.md
ARASHI_THREAD_ARBITER -- requirements
Module: arashi_thread_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of a thread-cache data word.
REQ-002 Parameter NUM_THREADS, default 4, number of thread caches served; power of two, 2..16.
REQ-003 Parameter OUT_DEPTH, default 4, output buffer entries; power of two, >= 4.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 avail  input  NUM_THREADS  per-thread cache avail: bit k high means cache k holds data next cycle.
REQ-007 cache_data  input  NUM_THREADS x DATA_WIDTH  per-thread cache data_out.
REQ-008 r_ena  output  NUM_THREADS  per-thread read enable; registered, at most one bit high.
REQ-009 out_valid  output  1  output buffer non-empty.
REQ-010 out_data  output  DATA_WIDTH  head-of-buffer word.
REQ-011 out_tid  output  clog2(NUM_THREADS)  thread index of out_data.
REQ-012 out_ready  input  1  consumer accepts head when out_valid and out_ready both high.

Function
REQ-013 Cache read contract: r_ena[k] high in cycle c SHALL cause the word to be captured from cache_data[k] in cycle c+1, with no valid qualifier other than this timing.
REQ-014 Grant decision SHALL use avail sampled in cycle c-1 to set r_ena for cycle c; r_ena SHALL NOT depend combinationally on avail.
REQ-015 Eligible threads in cycle c-1: avail[k] high.
REQ-016 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod NUM_THREADS, wrapping; after reset, last granted = NUM_THREADS-1, so thread 0 has highest priority.
REQ-017 Consecutive-cycle grants to the same thread are permitted when it is the only eligible thread.
REQ-018 pending = number of reads issued whose word is not yet written to the buffer (0..2); count = buffer occupancy.
REQ-019 A grant SHALL be issued only if count + pending < OUT_DEPTH, evaluated before any same-cycle pop (no credit for pops).
REQ-020 No eligible thread or no space: r_ena all-zero next cycle; last granted unchanged.
REQ-021 Captured word and its tid SHALL be written at tail in cycle c+1; out_valid rises in cycle c+2; end-to-end latency from r_ena to out_valid = 2 cycles.
REQ-022 Simultaneous write and pop SHALL both occur; count unchanged.
REQ-023 Pop with count==0 SHALL never occur; buffer overflow is unreachable by REQ-019; both are assertion targets.
REQ-024 Pointers SHALL wrap modulo OUT_DEPTH; count width clog2(OUT_DEPTH)+1.
REQ-025 Sustained throughput SHALL be one word per cycle when one or more threads stay available and out_ready stays high.
REQ-026 Output order SHALL equal grant order; per-thread order SHALL be preserved.

Reset
REQ-027 While rstn low: r_ena=0, out_valid=0, out_data=0, out_tid=0, count=0, pending=0, pointers=0, last granted=NUM_THREADS-1.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight words; cache_data arriving in the cycle after reset release SHALL be ignored.
REQ-029 First grant possible in the first cycle after rstn deasserts, using that cycle's avail; r_ena is high no earlier than the second cycle.

Structure
REQ-030 Package arashi_pkg SHALL hold the tid width function and the default NUM_THREADS and OUT_DEPTH constants.
REQ-031 Round-robin grant logic SHALL be a sub-module arashi_rr_picker (request vector, last index -> one-hot grant, index, any).
REQ-032 Output buffer SHALL be inline in this module; implementation 120-400 lines.

Verification
REQ-033 avail=4'b0101 constant, out_ready=1 after reset -> r_ena sequence 0001,0100,0001,...; out_tid 0,2,0,... with 2-cycle latency.
REQ-034 Only thread 3 avail, cache supplies 0xA1,0xA2,0xA3 -> r_ena=1000 for 3 consecutive cycles; out_data A1,A2,A3, out_tid=3.
REQ-035 All avail, out_ready=0 -> exactly OUT_DEPTH (4) grants, then r_ena=0; out_ready=1 resumes 1 word/cycle with no loss or duplication.
REQ-036 Full buffer with simultaneous pop and incoming write -> count stays 4; order preserved.
REQ-037 rstn low for 1 cycle with 2 words buffered and 1 in flight -> out_valid=0 next cycle; the in-flight word never appears.
REQ-038 Random avail/out_ready for 10k cycles against four arashi_thread_cache instances -> scoreboard matches per-thread order; one-hot r_ena holds throughout.
